sram_ctrl: RTL and testbench

- Synchronous initiator for the external asynchronous SRAM.
- Converts single-cycle host read/write requests into correctly sequenced ce_a_n/oe_n/we_n strobes, address and bidirectional data on the SRAM pins.
- Sits between the system bus (host side) and the SRAM device model/pads.
- All pin outputs are registered, so strobes are glitch-free.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_dq_buf.sv | 15 +
 rtl/sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM initiator.
// Strobe vectors are ordered {ce_a_n, oe_n, we_n}.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] STROBE_IDLE = 3'b111;
    localparam logic [2:0] STROBE_RD   = 3'b001;
    localparam logic [2:0] STROBE_WR   = 3'b010;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state driver for the SRAM data pins; kept separate so a pad cell
// can replace it without touching the controller.
module sram_dq_buf #(
    parameter int DATA_W = 16
) (
    input  logic              drive,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad = drive ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an external asynchronous SRAM. Every pin output,
// including the data-bus enable, comes straight from a flop.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_f2s,
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ad,
    output logic              ce_a_n,
    output logic              oe_n,
    output logic              we_n,
    inout  wire  [DATA_W-1:0] dio_a
);

    localparam int MAX_CYC = max_int(RD_CYC, WR_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          strb_q, strb_d;
    logic                drv_q, drv_d;
    logic                ready_q, ready_d;
    logic                load, capture;
    logic [ADDR_W-1:0]   ad_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   dq_in;

    // Next-state decode also produces the next pin values, so the flops
    // below carry the strobes with no combinational path to the pins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        strb_d  = STROBE_IDLE;
        drv_d   = 1'b0;
        ready_d = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem) begin
                    load = 1'b1;
                    if (rw) begin
                        state_d = RD;
                        cnt_d   = CNT_W'(RD_CYC);
                        strb_d  = STROBE_RD;
                    end else begin
                        state_d = WR;
                        cnt_d   = CNT_W'(WR_CYC);
                        strb_d  = STROBE_WR;
                        drv_d   = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            RD: begin
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    strb_d = STROBE_RD;
                end
            end
            WR: begin
                drv_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    strb_d = STROBE_WR;
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            strb_q     <= STROBE_IDLE;
            drv_q      <= 1'b0;
            ready_q    <= 1'b1;
            ad_q       <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            strb_q     <= strb_d;
            drv_q      <= drv_d;
            ready_q    <= ready_d;
            rd_valid_q <= capture;
            if (load) begin
                ad_q    <= addr;
                wdata_q <= data_f2s;
            end
            if (capture)
                rd_data_q <= dq_in;
        end
    end

    sram_dq_buf #(.DATA_W(DATA_W)) u_dq_buf (
        .drive (drv_q),
        .dout  (wdata_q),
        .din   (dq_in),
        .pad   (dio_a)
    );

    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ad       = ad_q;
    assign ce_a_n   = strb_q[2];
    assign oe_n     = strb_q[1];
    assign we_n     = strb_q[0];

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural async SRAM on the pins.
module tb_sram_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_f2s;
    logic          ready, rd_valid, ce_a_n, oe_n, we_n;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ad;
    wire  [DW-1:0] dio_a;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYC(2), .WR_CYC(2)) dut (
        .clk(clk), .reset(reset), .mem(mem), .rw(rw), .addr(addr),
        .data_f2s(data_f2s), .ready(ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .ad(ad), .ce_a_n(ce_a_n), .oe_n(oe_n),
        .we_n(we_n), .dio_a(dio_a)
    );

    always #5 clk = ~clk;

    // device model and independent reference image
    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    assign dio_a = (!ce_a_n && !oe_n) ? sram[ad] : {DW{1'bz}};

    always @(posedge clk)
        if (!ce_a_n && !we_n) sram[ad] <= dio_a;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb_q[$];
    int            acc_cyc[$];
    int            n_acc = 0;
    int            n_rdv = 0;
    int            cyc = 0;
    logic [AW-1:0] exp_ad = '0;
    logic [DW-1:0] zz = {DW{1'bz}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // accept monitor: pushes the read expectation when the request is taken
    always @(posedge clk) begin
        cyc++;
        if (!reset && ready && mem) begin
            exp_ad = addr;
            n_acc++;
            acc_cyc.push_back(cyc);
            if (rw) sb_q.push_back(ref_mem[addr]);
        end
    end

    // per-cycle output monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid) begin
                n_rdv++;
                if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else                  chk("rd_data", rd_data, sb_q.pop_front());
            end
            if (!oe_n) begin
                chk("oe_we_excl", we_n, 1'b1);
                chk("oe_bus", dio_a, sram[ad]);
            end
            if (ready) chk("idle_bus_z", dio_a, zz);
            else       chk("ad_stable", ad, exp_ad);
        end
    end

    task automatic wait_ready();
        int b = 0;
        while (!ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // presents a request at a negedge; returns at the negedge of cycle 1
    task automatic start(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        mem = 1'b1; rw = r; addr = a; data_f2s = d;
        @(posedge clk);
        @(negedge clk);
        mem = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        start(1'b0, a, d);
        ref_mem[a] = d;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return v[15:0] * 16'd37 ^ 16'h5A5A ^ {14'd0, v[17:16]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int a0, r0, b;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        reset = 1'b1; mem = 1'b0; rw = 1'b0; addr = '0; data_f2s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_strb", {ce_a_n, oe_n, we_n}, 3'b111);
        chk("rst_bus", dio_a, zz);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_ad", ad, 18'h0);

        // write timing: we_n low in cycles 1-2, data held through cycle 3
        do_write(18'h00010, 16'hA5A5);
        chk("wr_c1_strb", {ce_a_n, oe_n, we_n}, 3'b010);
        chk("wr_c1_bus", dio_a, 16'hA5A5);
        chk("wr_c1_ready", ready, 1'b0);
        @(negedge clk);
        chk("wr_c2_strb", {ce_a_n, oe_n, we_n}, 3'b010);
        chk("wr_c2_bus", dio_a, 16'hA5A5);
        @(negedge clk);
        chk("wr_c3_strb", {ce_a_n, oe_n, we_n}, 3'b111);
        chk("wr_c3_bus", dio_a, 16'hA5A5);
        chk("wr_c3_ready", ready, 1'b0);
        @(negedge clk);
        chk("wr_c4_ready", ready, 1'b1);
        chk("wr_c4_bus", dio_a, zz);

        // read timing: oe_n low cycles 1-2, rd_valid in cycle 3
        start(1'b1, 18'h00010, '0);
        chk("rd_c1_strb", {ce_a_n, oe_n, we_n}, 3'b001);
        chk("rd_c1_vld", rd_valid, 1'b0);
        @(negedge clk);
        chk("rd_c2_strb", {ce_a_n, oe_n, we_n}, 3'b001);
        chk("rd_c2_vld", rd_valid, 1'b0);
        @(negedge clk);
        chk("rd_c3_vld", rd_valid, 1'b1);
        chk("rd_c3_data", rd_data, 16'hA5A5);
        chk("rd_c3_ready", ready, 1'b1);
        chk("rd_c3_strb", {ce_a_n, oe_n, we_n}, 3'b111);
        @(negedge clk);
        chk("rd_c4_vld", rd_valid, 1'b0);

        // address extremes
        do_write(18'h00000, 16'hFFFF);
        do_write(18'h3FFFF, 16'h0001);
        start(1'b1, 18'h00000, '0);
        start(1'b1, 18'h3FFFF, '0);
        repeat (3) @(negedge clk);
        chk("rd_ext_hi", rd_data, 16'h0001);
        do_write(18'h00020, 16'h7E7E);
        repeat (3) @(negedge clk);
        chk("rd_data_keep", rd_data, 16'h0001);

        // back-to-back reads with mem held high and addr moving every cycle
        wait_ready();
        a0 = n_acc; r0 = n_rdv; b = 0;
        mem = 1'b1; rw = 1'b1;
        while (n_acc - a0 < 8 && b < 100) begin
            addr = 18'h00100 + 18'(b);
            @(negedge clk);
            b++;
        end
        mem = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_accepts", n_acc - a0, 32'd8);
        chk("b2b_rd_valid", n_rdv - r0, 32'd8);
        for (int k = acc_cyc.size() - 7; k < acc_cyc.size(); k++)
            chk("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], 32'd3);

        // async reset in cycle 1 of a write
        start(1'b0, 18'h00200, 16'h1234);
        chk("rstw_we_low", we_n, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("rstw_strb", {ce_a_n, oe_n, we_n}, 3'b111);
        chk("rstw_bus", dio_a, zz);
        chk("rstw_ready", ready, 1'b1);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("rstw_ready_after", ready, 1'b1);

        // async reset mid-read must swallow the rd_valid pulse
        r0 = n_rdv;
        start(1'b1, 18'h00010, '0);
        #1 reset = 1'b1;
        #1;
        chk("rstr_strb", {ce_a_n, oe_n, we_n}, 3'b111);
        chk("rstr_rd_data", rd_data, 16'h0);
        sb_q.delete();
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstr_no_vld", n_rdv - r0, 32'd0);

        // controller still functional after reset
        start(1'b1, 18'h3FFFF, '0);
        repeat (4) @(negedge clk);
        chk("post_rst_rd", rd_data, 16'h0001);
        chk("sb_drain", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
